// File: rtl/kgp_pc_pkg.sv
// kgp_pc_pkg: shared types and constants for the next-address generator.
//   br_type_e : decoded branch kind presented by the instruction decoder
//   state_e   : next_addr_gen control state (RUN / STALL / HALT)
//   ADDR_INC  : sequential PC increment in bytes
package kgp_pc_pkg;

   typedef enum logic [2:0] {
      BR_NONE = 3'd0,
      BR_B    = 3'd1,
      BR_BZ   = 3'd2,
      BR_BNZ  = 3'd3,
      BR_BCY  = 3'd4,
      BR_BNCY = 3'd5,
      BR_BLTZ = 3'd6,
      BR_BR   = 3'd7
   } br_type_e;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_HALT  = 2'd2
   } state_e;

   localparam int unsigned ADDR_INC = 32'd4;

endpackage : kgp_pc_pkg

// File: rtl/br_cond_eval.sv
// br_cond_eval: purely combinational branch-condition evaluator.
// Ports:
//   br_type  in  3  branch kind (kgp_pc_pkg::br_type_e encoding)
//   flag_z   in  1  ALU zero flag
//   flag_c   in  1  ALU carry flag
//   flag_n   in  1  ALU negative flag
//   taken    out 1  condition of this branch kind is satisfied
module br_cond_eval
   import kgp_pc_pkg::*;
(
   input  logic [2:0] br_type,
   input  logic       flag_z,
   input  logic       flag_c,
   input  logic       flag_n,
   output logic       taken
);

   // Map branch kind and flags onto the taken decision.
   always_comb begin
      taken = 1'b0;
      case (br_type_e'(br_type))
         BR_NONE: taken = 1'b0;
         BR_B:    taken = 1'b1;
         BR_BZ:   taken = flag_z;
         BR_BNZ:  taken = ~flag_z;
         BR_BCY:  taken = flag_c;
         BR_BNCY: taken = ~flag_c;
         BR_BLTZ: taken = flag_n;
         BR_BR:   taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

endmodule : br_cond_eval

// File: rtl/next_addr_gen.sv
// next_addr_gen: computes the address the program counter loads on the next
// edge (sequential, PC-relative branch or register branch), holds the PC on
// stall while remembering a branch that arrived during the stall, freezes the
// PC in HALT until reset, and strobes the link register for bl.
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   instr_addr      current PC
//   br_valid/br_type/br_link/br_imm/rs_val   decoded branch controls
//   flag_z/flag_c/flag_n                     ALU flags
//   stall, halt_req                          pipeline hold / halt request
//   next_addr       address for the PC register (combinational)
//   link_addr, link_we                       link-register write port
//   halted          high in HALT
//   misalign_err    sticky: a redirect target had addr[1:0] != 0
//   br_taken_cnt    saturating count of redirects
module next_addr_gen
   import kgp_pc_pkg::*;
#(
   parameter int unsigned        ADDR_W     = 32,
   parameter int unsigned        IMM_W      = 26,
   parameter logic [ADDR_W-1:0]  RESET_ADDR = {ADDR_W{1'b0}}
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] instr_addr,
   input  logic              br_valid,
   input  logic [2:0]        br_type,
   input  logic              br_link,
   input  logic [IMM_W-1:0]  br_imm,
   input  logic [ADDR_W-1:0] rs_val,
   input  logic              flag_z,
   input  logic              flag_c,
   input  logic              flag_n,
   input  logic              stall,
   input  logic              halt_req,
   output logic [ADDR_W-1:0] next_addr,
   output logic [ADDR_W-1:0] link_addr,
   output logic              link_we,
   output logic              halted,
   output logic              misalign_err,
   output logic [15:0]       br_taken_cnt
);

   state_e            state_q, state_d;
   logic              pend_valid_q, pend_valid_d;
   logic [ADDR_W-1:0] pend_target_q, pend_target_d;
   logic              pend_link_q, pend_link_d;
   logic [ADDR_W-1:0] pend_link_addr_q, pend_link_addr_d;
   logic              misalign_q, misalign_d;
   logic [15:0]       cnt_q, cnt_d;

   logic              cond_taken_s;
   logic              taken_s;
   logic [ADDR_W-1:0] seq_addr_s;
   logic [ADDR_W-1:0] imm_off_s;
   logic [ADDR_W-1:0] br_target_s;

   logic              redirect_s;
   logic [ADDR_W-1:0] redir_target_s;
   logic              redir_link_s;
   logic [ADDR_W-1:0] redir_link_addr_s;
   logic [ADDR_W-1:0] next_addr_s;
   logic              link_we_s;
   logic [ADDR_W-1:0] link_addr_s;

   br_cond_eval u_cond (
      .br_type (br_type),
      .flag_z  (flag_z),
      .flag_c  (flag_c),
      .flag_n  (flag_n),
      .taken   (cond_taken_s)
   );

   assign taken_s    = br_valid & cond_taken_s;
   assign seq_addr_s = instr_addr + ADDR_W'(ADDR_INC);
   // Sign-extend the word offset, then scale to bytes; bits shifted out are
   // intentionally lost because address arithmetic wraps.
   assign imm_off_s  = {{(ADDR_W-IMM_W){br_imm[IMM_W-1]}}, br_imm} << 2;
   assign br_target_s = (br_type == BR_BR) ? rs_val : (instr_addr + imm_off_s);

   // Next-state, pending-branch, counter and next_addr/link selection.
   always_comb begin
      state_d           = state_q;
      pend_valid_d      = pend_valid_q;
      pend_target_d     = pend_target_q;
      pend_link_d       = pend_link_q;
      pend_link_addr_d  = pend_link_addr_q;
      misalign_d        = misalign_q;
      cnt_d             = cnt_q;
      redirect_s        = 1'b0;
      redir_target_s    = br_target_s;
      redir_link_s      = br_link;
      redir_link_addr_s = seq_addr_s;
      next_addr_s       = instr_addr;
      link_we_s         = 1'b0;
      link_addr_s       = seq_addr_s;

      case (state_q)
         ST_RUN, ST_STALL: begin
            if (stall) begin
               next_addr_s = instr_addr;
               state_d     = ST_STALL;
               // Latest taken branch seen while stalled wins.
               if (taken_s) begin
                  pend_valid_d     = 1'b1;
                  pend_target_d    = br_target_s;
                  pend_link_d      = br_link;
                  pend_link_addr_d = seq_addr_s;
               end else begin
                  pend_valid_d     = pend_valid_q;
               end
            end else if (halt_req) begin
               next_addr_s  = instr_addr;
               state_d      = ST_HALT;
               pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
               // Release a branch that was captured during the stall.
               state_d           = ST_RUN;
               pend_valid_d      = 1'b0;
               redirect_s        = 1'b1;
               redir_target_s    = pend_target_q;
               redir_link_s      = pend_link_q;
               redir_link_addr_s = pend_link_addr_q;
            end else if (taken_s) begin
               state_d    = ST_RUN;
               redirect_s = 1'b1;
            end else begin
               state_d     = ST_RUN;
               next_addr_s = seq_addr_s;
            end
         end
         ST_HALT: begin
            next_addr_s = instr_addr;
            state_d     = ST_HALT;
         end
         default: begin
            next_addr_s  = instr_addr;
            state_d      = ST_RUN;
            pend_valid_d = 1'b0;
         end
      endcase

      if (redirect_s) begin
         next_addr_s = redir_target_s;
         link_we_s   = redir_link_s;
         link_addr_s = redir_link_addr_s;
         if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
         end else begin
            cnt_d = cnt_q;
         end
         // A misaligned target is still taken, then the core halts.
         if (redir_target_s[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            state_d    = ST_HALT;
         end else begin
            misalign_d = misalign_q;
         end
      end else begin
         link_we_s = 1'b0;
      end

      if (rst) begin
         next_addr_s = RESET_ADDR;
         link_we_s   = 1'b0;
      end else begin
         link_we_s   = link_we_s;
      end
   end

   // State, pending-branch and status registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= ST_RUN;
         pend_valid_q     <= 1'b0;
         pend_target_q    <= {ADDR_W{1'b0}};
         pend_link_q      <= 1'b0;
         pend_link_addr_q <= {ADDR_W{1'b0}};
         misalign_q       <= 1'b0;
         cnt_q            <= 16'd0;
      end else begin
         state_q          <= state_d;
         pend_valid_q     <= pend_valid_d;
         pend_target_q    <= pend_target_d;
         pend_link_q      <= pend_link_d;
         pend_link_addr_q <= pend_link_addr_d;
         misalign_q       <= misalign_d;
         cnt_q            <= cnt_d;
      end
   end

   assign next_addr    = next_addr_s;
   assign link_addr    = link_addr_s;
   assign link_we      = link_we_s;
   assign halted       = (state_q == ST_HALT);
   assign misalign_err = misalign_q;
   assign br_taken_cnt = cnt_q;

endmodule : next_addr_gen

// File: tb/tb_next_addr_gen.sv
// tb_next_addr_gen: closes the PC loop around next_addr_gen with a bench-side
// program-counter register. Each driven cycle pushes its hand-computed
// expectation into a queue; a monitor on the falling edge pops and compares.
module tb_next_addr_gen;
   import kgp_pc_pkg::*;

   logic        clk;
   logic        rst;
   logic [31:0] pc_q;
   logic        br_valid;
   logic [2:0]  br_type;
   logic        br_link;
   logic [25:0] br_imm;
   logic [31:0] rs_val;
   logic        flag_z, flag_c, flag_n;
   logic        stall, halt_req;
   logic [31:0] next_addr, link_addr;
   logic        link_we, halted, misalign_err;
   logic [15:0] br_taken_cnt;

   typedef struct {
      logic [31:0] pc;
      logic        h;
      logic [15:0] cnt;
      logic        m;
      logic        lwe;
      logic [31:0] la;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   next_addr_gen #(.ADDR_W(32), .IMM_W(26), .RESET_ADDR(32'h0)) dut (
      .clk          (clk),
      .rst          (rst),
      .instr_addr   (pc_q),
      .br_valid     (br_valid),
      .br_type      (br_type),
      .br_link      (br_link),
      .br_imm       (br_imm),
      .rs_val       (rs_val),
      .flag_z       (flag_z),
      .flag_c       (flag_c),
      .flag_n       (flag_n),
      .stall        (stall),
      .halt_req     (halt_req),
      .next_addr    (next_addr),
      .link_addr    (link_addr),
      .link_we      (link_we),
      .halted       (halted),
      .misalign_err (misalign_err),
      .br_taken_cnt (br_taken_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Program counter closing the loop.
   always_ff @(posedge clk) pc_q <= next_addr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compare one expectation per cycle, away from the active edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc", pc_q, e.pc);
            chk("halted", {31'd0, halted}, {31'd0, e.h});
            chk("br_taken_cnt", {16'd0, br_taken_cnt}, {16'd0, e.cnt});
            chk("misalign_err", {31'd0, misalign_err}, {31'd0, e.m});
            chk("link_we", {31'd0, link_we}, {31'd0, e.lwe});
            if (e.lwe) chk("link_addr", link_addr, e.la);
         end
      end
   end

   // Drive one cycle of inputs and queue the values expected during it.
   task automatic cyc(input logic r, input logic bv, input logic [2:0] bt, input logic lk,
                      input int imm, input logic [31:0] rs, input logic [2:0] zcn,
                      input logic st, input logic hr,
                      input logic [31:0] e_pc, input logic e_h, input int e_cnt,
                      input logic e_m, input logic e_lwe, input logic [31:0] e_la);
      exp_t e;
      rst      = r;
      br_valid = bv;
      br_type  = bt;
      br_link  = lk;
      br_imm   = imm[25:0];
      rs_val   = rs;
      {flag_z, flag_c, flag_n} = zcn;
      stall    = st;
      halt_req = hr;
      e.pc = e_pc; e.h = e_h; e.cnt = e_cnt[15:0]; e.m = e_m; e.lwe = e_lwe; e.la = e_la;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; br_valid = 1'b0; br_type = BR_NONE; br_link = 1'b0; br_imm = 26'd0;
      rs_val = 32'd0; flag_z = 1'b0; flag_c = 1'b0; flag_n = 1'b0; stall = 1'b0; halt_req = 1'b0;
      @(posedge clk); #1;
      // Reset: second reset cycle with a bl present must not strobe link.
      cyc(1, 1, BR_B,    1,   5, 32'h0,        3'b000, 0, 0, 32'h00, 0, 0, 0, 0, 32'h0);
      // Sequential fetch.
      cyc(0, 0, BR_NONE, 0,   0, 32'h0,        3'b000, 0, 0, 32'h00, 0, 0, 0, 0, 32'h0);
      cyc(0, 0, BR_NONE, 0,   0, 32'h0,        3'b000, 0, 0, 32'h04, 0, 0, 0, 0, 32'h0);
      cyc(0, 0, BR_NONE, 0,   0, 32'h0,        3'b000, 0, 0, 32'h08, 0, 0, 0, 0, 32'h0);
      cyc(0, 0, BR_NONE, 0,   0, 32'h0,        3'b000, 0, 0, 32'h0C, 0, 0, 0, 0, 32'h0);
      // PC-relative branches.
      cyc(0, 1, BR_B,    0,  -2, 32'h0,        3'b000, 0, 0, 32'h10, 0, 0, 0, 0, 32'h0);
      cyc(0, 1, BR_BZ,   0,   3, 32'h0,        3'b000, 0, 0, 32'h08, 0, 1, 0, 0, 32'h0);
      cyc(0, 1, BR_BZ,   0,   2, 32'h0,        3'b100, 0, 0, 32'h0C, 0, 1, 0, 0, 32'h0);
      cyc(0, 0, BR_NONE, 0,   0, 32'h0,        3'b000, 0, 0, 32'h14, 0, 2, 0, 0, 32'h0);
      cyc(0, 1, BR_BCY,  0,   2, 32'h0,        3'b010, 0, 0, 32'h18, 0, 2, 0, 0, 32'h0);
      // Register branch with link.
      cyc(0, 1, BR_BR,   1,   0, 32'h100,      3'b000, 0, 0, 32'h20, 0, 3, 0, 1, 32'h24);
      cyc(0, 0, BR_NONE, 0,   0, 32'h0,        3'b000, 0, 0, 32'h100, 0, 4, 0, 0, 32'h0);
      cyc(0, 1, BR_BR,   0,   0, 32'h40,       3'b000, 0, 0, 32'h104, 0, 4, 0, 0, 32'h0);
      // Stall with a pending bl, released after three cycles.
      cyc(0, 1, BR_B,    1,   4, 32'h0,        3'b000, 1, 0, 32'h40, 0, 5, 0, 0, 32'h0);
      cyc(0, 1, BR_B,    1,   4, 32'h0,        3'b000, 1, 0, 32'h40, 0, 5, 0, 0, 32'h0);
      cyc(0, 1, BR_B,    1,   4, 32'h0,        3'b000, 1, 0, 32'h40, 0, 5, 0, 0, 32'h0);
      cyc(0, 0, BR_NONE, 0,   0, 32'h0,        3'b000, 0, 0, 32'h40, 0, 5, 0, 1, 32'h44);
      cyc(0, 0, BR_NONE, 0,   0, 32'h0,        3'b000, 0, 0, 32'h50, 0, 6, 0, 0, 32'h0);
      // Latest pended branch wins; release ignores the branch presented then.
      cyc(0, 1, BR_B,    0,   8, 32'h0,        3'b000, 1, 0, 32'h54, 0, 6, 0, 0, 32'h0);
      cyc(0, 1, BR_BNZ,  0,   2, 32'h0,        3'b000, 1, 0, 32'h54, 0, 6, 0, 0, 32'h0);
      cyc(0, 0, BR_NONE, 0,   0, 32'h0,        3'b000, 1, 0, 32'h54, 0, 6, 0, 0, 32'h0);
      cyc(0, 1, BR_B,    1,  -4, 32'h0,        3'b000, 0, 0, 32'h54, 0, 6, 0, 0, 32'h0);
      // Not-taken kinds, then a backward BNCY.
      cyc(0, 1, BR_BLTZ, 0,   5, 32'h0,        3'b100, 0, 0, 32'h5C, 0, 7, 0, 0, 32'h0);
      cyc(0, 1, BR_NONE, 0,   3, 32'h0,        3'b111, 0, 0, 32'h60, 0, 7, 0, 0, 32'h0);
      cyc(0, 1, BR_BNCY, 0, -13, 32'h0,        3'b000, 0, 0, 32'h64, 0, 7, 0, 0, 32'h0);
      // Halt beats a simultaneous taken bl; HALT ignores everything.
      cyc(0, 1, BR_B,    1,   4, 32'h0,        3'b000, 0, 1, 32'h30, 0, 8, 0, 0, 32'h0);
      cyc(0, 1, BR_B,    1,   4, 32'h0,        3'b000, 0, 0, 32'h30, 1, 8, 0, 0, 32'h0);
      cyc(0, 0, BR_NONE, 0,   0, 32'h0,        3'b000, 1, 1, 32'h30, 1, 8, 0, 0, 32'h0);
      cyc(1, 0, BR_NONE, 0,   0, 32'h0,        3'b000, 0, 0, 32'h30, 1, 8, 0, 0, 32'h0);
      // Wrap-around at the top of the address space.
      cyc(0, 1, BR_BR,   0,   0, 32'hFFFFFFFC, 3'b000, 0, 0, 32'h00, 0, 0, 0, 0, 32'h0);
      cyc(0, 0, BR_NONE, 0,   0, 32'h0,        3'b000, 0, 0, 32'hFFFFFFFC, 0, 1, 0, 0, 32'h0);
      // Misaligned register target: taken, then halted and frozen.
      cyc(0, 1, BR_BR,   0,   0, 32'h102,      3'b000, 0, 0, 32'h00, 0, 1, 0, 0, 32'h0);
      cyc(0, 1, BR_B,    0,   1, 32'h0,        3'b000, 0, 0, 32'h102, 1, 2, 1, 0, 32'h0);
      cyc(0, 0, BR_NONE, 0,   0, 32'h0,        3'b000, 0, 0, 32'h102, 1, 2, 1, 0, 32'h0);
      cyc(1, 0, BR_NONE, 0,   0, 32'h0,        3'b000, 0, 0, 32'h102, 1, 2, 1, 0, 32'h0);
      cyc(0, 0, BR_NONE, 0,   0, 32'h0,        3'b000, 0, 0, 32'h00, 0, 0, 0, 0, 32'h0);
      // Reset during STALL drops the pending branch.
      cyc(0, 1, BR_B,    0,  10, 32'h0,        3'b000, 1, 0, 32'h04, 0, 0, 0, 0, 32'h0);
      cyc(1, 0, BR_NONE, 0,   0, 32'h0,        3'b000, 1, 0, 32'h04, 0, 0, 0, 0, 32'h0);
      cyc(0, 0, BR_NONE, 0,   0, 32'h0,        3'b000, 0, 0, 32'h00, 0, 0, 0, 0, 32'h0);
      cyc(0, 0, BR_NONE, 0,   0, 32'h0,        3'b000, 0, 0, 32'h04, 0, 0, 0, 0, 32'h0);

      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_next_addr_gen
